// File: rtl/lcd_pkg.sv
// Shared types and default timing for the LCD access arbiter.
package lcd_pkg;

  typedef enum logic {
    OP_CHAR = 1'b0,
    OP_LINE = 1'b1
  } lcd_op_e;

  typedef logic [0:7][7:0] lcd_line_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } arb_state_e;

  localparam int unsigned CLOCK_HZ      = 50_000_000;
  // 50 us per char, 1.2 ms for a full line rewrite
  localparam int unsigned DEF_CHAR_WAIT = CLOCK_HZ / 20_000;
  localparam int unsigned DEF_LINE_WAIT = (CLOCK_HZ / 10_000) * 12;

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m == 0) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/lcd_access_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit after 'last', wrapping.
module rr_pick #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last,
  output logic            valid,
  output logic [IDXW-1:0] index
);

  always_comb begin
    int unsigned cand;
    cand  = 0;
    valid = 1'b0;
    index = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = (32'(last) + k) % NREQ;
      if (!valid && req[cand]) begin
        valid = 1'b1;
        index = IDXW'(cand);
      end
    end
  end

endmodule

// File: rtl/lcd_access_arbiter.sv
// Arbitrates several requesters onto one LCD driver: pick, strobe once, then hold off.
module lcd_access_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned NREQ      = 3,
  parameter int unsigned CHAR_WAIT = DEF_CHAR_WAIT,
  parameter int unsigned LINE_WAIT = DEF_LINE_WAIT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    op,
  input  logic [NREQ*4-1:0]  pos,
  input  logic [NREQ*8-1:0]  data,
  input  logic [NREQ*64-1:0] line,
  output logic [NREQ-1:0]    ack,
  output logic               busy,
  output logic               wEn,
  output logic               wLineEn,
  output logic [3:0]         charNum,
  output logic [7:0]         dIn,
  output logic [63:0]        lineIn
);

  localparam int unsigned IDXW = $clog2(NREQ);
  localparam int unsigned CNTW = cnt_width(CHAR_WAIT, LINE_WAIT);

  arb_state_e      state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [IDXW-1:0] last_q, last_d;
  logic [IDXW-1:0] win_q, win_d;
  lcd_op_e         op_q, op_d;
  logic [3:0]      pos_q, pos_d;
  logic [7:0]      data_q, data_d;
  lcd_line_t       line_q, line_d;

  logic            pick_valid;
  logic [IDXW-1:0] pick_idx;

  rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr_pick (
    .req   (req),
    .last  (last_q),
    .valid (pick_valid),
    .index (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    win_d   = win_q;
    op_d    = op_q;
    pos_d   = pos_q;
    data_d  = data_q;
    line_d  = line_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          last_d  = pick_idx;
          win_d   = pick_idx;
          op_d    = lcd_op_e'(op[pick_idx]);
          pos_d   = pos[int'(pick_idx)*4 +: 4];
          data_d  = data[int'(pick_idx)*8 +: 8];
          line_d  = line[int'(pick_idx)*64 +: 64];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = (op_q == OP_LINE) ? CNTW'(LINE_WAIT) : CNTW'(CHAR_WAIT);
        state_d = (cnt_d == '0) ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        // Leaving on the count-of-1 cycle makes WAIT last exactly the loaded value
        if (cnt_q <= CNTW'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= IDXW'(NREQ - 1);
      win_q   <= '0;
      op_q    <= OP_CHAR;
      pos_q   <= '0;
      data_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      win_q   <= win_d;
      op_q    <= op_d;
      pos_q   <= pos_d;
      data_q  <= data_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    ack = '0;
    if (state_q == ST_ISSUE) ack[win_q] = 1'b1;
  end

  assign busy    = (state_q != ST_IDLE);
  assign wEn     = (state_q == ST_ISSUE) && (op_q == OP_CHAR);
  assign wLineEn = (state_q == ST_ISSUE) && (op_q == OP_LINE);
  assign charNum = pos_q;
  assign dIn     = data_q;
  assign lineIn  = line_q;

endmodule
